// File: rtl/i2c_cmd_sequencer.sv
// i2c_cmd_sequencer: queues i2c commands in a small FIFO and issues them one
// at a time to an external i2c block. Each transaction is a setup cycle, a
// one-cycle en pulse and a fixed wait window. Reads then capture the returned
// data and pulse rsp_valid for one cycle.
module i2c_cmd_sequencer #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned WAIT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_slave_address,
    input  logic        cmd_read_write,
    input  logic [7:0]  cmd_register_address,
    input  logic [31:0] cmd_data,
    output logic        en,
    output logic [6:0]  ext_slave_address_in,
    output logic        ext_read_write_in,
    output logic [7:0]  ext_register_address_in,
    output logic [31:0] ext_data_in,
    input  logic [31:0] ext_data_out,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LOAD  = WW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        WAIT,
        CAPTURE
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;

    // Command FIFO: {slave address, rw, register, data}
    logic [47:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [47:0]   head;

    // Readiness looks only at the registered count, so a pop in the same
    // cycle never makes room for a push into a full FIFO.
    assign cmd_ready = (count < FULL_COUNT);
    assign push      = cmd_valid & cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = fifo_mem[rd_ptr];
    assign busy      = (count != '0) || (state != IDLE);

    // FIFO storage write; contents are don't-care until pointed at
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_slave_address, cmd_read_write,
                                 cmd_register_address, cmd_data};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Transaction sequencer with registered en, response and ext_* fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                   <= IDLE;
            wait_cnt                <= '0;
            en                      <= 1'b0;
            rsp_valid               <= 1'b0;
            rsp_data                <= '0;
            ext_slave_address_in    <= '0;
            ext_read_write_in       <= 1'b0;
            ext_register_address_in <= '0;
            ext_data_in             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        {ext_slave_address_in, ext_read_write_in,
                         ext_register_address_in, ext_data_in} <= head;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    en    <= 1'b1;
                    state <= PULSE;
                end
                PULSE: begin
                    en       <= 1'b0;
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        if (ext_read_write_in) begin
                            rsp_data  <= ext_data_out;
                            rsp_valid <= 1'b1;
                            state     <= CAPTURE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WW'(1);
                    end
                end
                CAPTURE: begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Testbench for i2c_cmd_sequencer: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-age reference model.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int W     = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_slave_address;
    logic        cmd_read_write;
    logic [7:0]  cmd_register_address;
    logic [31:0] cmd_data;
    logic        en;
    logic [6:0]  ext_slave_address_in;
    logic        ext_read_write_in;
    logic [7:0]  ext_register_address_in;
    logic [31:0] ext_data_in;
    logic [31:0] ext_data_out;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_cmd_sequencer #(
        .DEPTH      (DEPTH),
        .WAIT_CYCLES(W)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .cmd_valid              (cmd_valid),
        .cmd_ready              (cmd_ready),
        .cmd_slave_address      (cmd_slave_address),
        .cmd_read_write         (cmd_read_write),
        .cmd_register_address   (cmd_register_address),
        .cmd_data               (cmd_data),
        .en                     (en),
        .ext_slave_address_in   (ext_slave_address_in),
        .ext_read_write_in      (ext_read_write_in),
        .ext_register_address_in(ext_register_address_in),
        .ext_data_in            (ext_data_in),
        .ext_data_out           (ext_data_out),
        .rsp_valid              (rsp_valid),
        .rsp_data               (rsp_data),
        .busy                   (busy)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of accepted commands and the age (edges since
    // pop) of the transaction in flight. A write occupies the sequencer for
    // W+2 edges, a read W+3; en is seen at age 1, read data at age W+2.
    logic [47:0] mq[$];
    bit          m_active = 1'b0;
    int          m_age    = 0;
    logic [47:0] m_cur    = '0;
    logic [31:0] m_rsp    = '0;
    int          m_acc    = 0;
    bit          m_take;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_age    = 0;
            m_cur    = '0;
            m_rsp    = '0;
        end else begin
            m_take = cmd_valid && (mq.size() < DEPTH);
            if (m_active) begin
                m_age++;
                if (m_cur[40] && m_age == W + 2) m_rsp = ext_data_out;
                if (m_age == (m_cur[40] ? W + 3 : W + 2)) m_active = 1'b0;
            end else if (mq.size() != 0) begin
                m_cur    = mq.pop_front();
                m_active = 1'b1;
                m_age    = 0;
            end
            if (m_take) begin
                mq.push_back({cmd_slave_address, cmd_read_write, cmd_register_address, cmd_data});
                m_acc++;
            end
        end
    end

    function automatic logic [83:0] exp_vec();
        logic e, rv, b, r;
        e  = m_active && (m_age == 1);
        rv = m_active && m_cur[40] && (m_age == W + 2);
        b  = (mq.size() != 0) || m_active;
        r  = (mq.size() < DEPTH);
        return {e, rv, b, r, m_cur, m_rsp};
    endfunction

    function automatic logic [83:0] dut_vec();
        return {en, rsp_valid, busy, cmd_ready, ext_slave_address_in, ext_read_write_in,
                ext_register_address_in, ext_data_in, rsp_data};
    endfunction

    function automatic logic [47:0] rnd48(input logic rw);
        logic [47:0] c;
        c      = {16'($urandom), $urandom};
        c[40]  = rw;
        return c;
    endfunction

    // Drive one cycle of inputs from a falling edge, return at the next one
    task automatic step(input logic v, input logic [47:0] c, input logic [31:0] rd);
        cmd_valid = v;
        {cmd_slave_address, cmd_read_write, cmd_register_address, cmd_data} = c;
        ext_data_out = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        {cmd_slave_address, cmd_read_write, cmd_register_address, cmd_data} = '0;
        ext_data_out = '0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dut_vec() !== {4'b0001, 80'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h, want %h", dut_vec(), {4'b0001, 80'h0});
        end
        rst = 1'b0;
        step(1'b0, '0, '0);
        n_checks++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_release: got %h, want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_single_write();
        logic [47:0] c;
        int en_cnt, en_at, busy_low_at, rv_cnt, ext_bad;
        c = {7'h63, 1'b0, 8'h0b, 32'h58ae1234};
        en_cnt = 0; en_at = -1; busy_low_at = -1; rv_cnt = 0; ext_bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(i == 0, (i == 0) ? c : rnd48(1'b1), $urandom);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL write_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (en) begin en_cnt++; if (en_at < 0) en_at = i; end
            if (rsp_valid) rv_cnt++;
            if (i >= 1 && i <= 11 &&
                {ext_slave_address_in, ext_read_write_in, ext_register_address_in, ext_data_in} !== c)
                ext_bad++;
            if (!busy && busy_low_at < 0) busy_low_at = i;
        end
        n_checks++;
        if (en_cnt != 1 || en_at != 2) begin
            n_fail++;
            $display("FAIL write_en_pulse: got count %0d at %0d, want count 1 at 2", en_cnt, en_at);
        end
        n_checks++;
        if (ext_bad != 0) begin
            n_fail++;
            $display("FAIL write_ext_hold: got %0d bad cycles, want 0", ext_bad);
        end
        n_checks++;
        if (busy_low_at != 11 || rv_cnt != 0) begin
            n_fail++;
            $display("FAIL write_busy_rsp: got busy low at %0d rsp %0d, want 11 and 0", busy_low_at, rv_cnt);
        end
    endtask

    task automatic test_single_read();
        logic [47:0] c;
        int en_at, rv_cnt, rv_at;
        c = {7'h63, 1'b1, 8'h0f, 32'h0};
        en_at = -1; rv_cnt = 0; rv_at = -1;
        for (int i = 0; i < 16; i++) begin
            step(i == 0, (i == 0) ? c : rnd48(1'b0), 32'hdeadbeef);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL read_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (en && en_at < 0) en_at = i;
            if (rsp_valid) begin rv_cnt++; if (rv_at < 0) rv_at = i; end
        end
        n_checks++;
        if (rv_cnt != 1 || rv_at != 11 || en_at != 2) begin
            n_fail++;
            $display("FAIL read_timing: got rsp %0d at %0d en at %0d, want 1 at 11 en at 2", rv_cnt, rv_at, en_at);
        end
        n_checks++;
        if (rsp_data !== 32'hdeadbeef) begin
            n_fail++;
            $display("FAIL read_data: got %h, want deadbeef", rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        int en_t[$];
        logic [31:0] en_d[$];
        logic rdy3, rdy4;
        int bad_gap;
        rdy3 = 1'bx; rdy4 = 1'bx;
        for (int i = 0; i < 62; i++) begin
            step(i < 6, (i < 6) ? {7'h21, 1'b0, 8'h40, 32'(i + 1)} : rnd48(1'b0), $urandom);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL b2b_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (en) begin en_t.push_back(i); en_d.push_back(ext_data_in); end
            if (i == 3) rdy3 = cmd_ready;
            if (i == 4) rdy4 = cmd_ready;
        end
        n_checks++;
        if ({rdy3, rdy4} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_ready: got %b%b, want 10", rdy3, rdy4);
        end
        n_checks++;
        if (en_t.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d en pulses, want 5", en_t.size());
        end
        bad_gap = 0;
        for (int k = 1; k < en_t.size(); k++)
            if (en_t[k] - en_t[k-1] != W + 3) bad_gap++;
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d bad gaps, want 0", bad_gap);
        end
        for (int k = 0; k < en_d.size(); k++) begin
            n_checks++;
            if (en_d[k] !== 32'(k + 1)) begin
                n_fail++;
                $display("FAIL b2b_order %0d: got %h, want %h", k, en_d[k], 32'(k + 1));
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] en_d[$];
        logic [31:0] want[6];
        logic [2:0] rdy;
        int base;
        bit v;
        want = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hF0};
        base = m_acc;
        rdy  = 'x;
        for (int i = 0; i < 70; i++) begin
            v = (i < 5) || (m_acc < base + 6);
            step(v, {7'h12, 1'b0, 8'h34, (i < 5) ? 32'(32'hA0 + i) : 32'hF0}, $urandom);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL full_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (en) en_d.push_back(ext_data_in);
            if (i >= 11 && i <= 13) rdy[13 - i] = cmd_ready;
        end
        n_checks++;
        if (rdy !== 3'b010) begin
            n_fail++;
            $display("FAIL full_ready_11_13: got %b, want 010", rdy);
        end
        n_checks++;
        if (en_d.size() != 6) begin
            n_fail++;
            $display("FAIL full_count: got %0d en pulses, want 6", en_d.size());
        end
        for (int k = 0; k < en_d.size() && k < 6; k++) begin
            n_checks++;
            if (en_d[k] !== want[k]) begin
                n_fail++;
                $display("FAIL full_order %0d: got %h, want %h", k, en_d[k], want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int en_cnt, rv_cnt;
        for (int i = 0; i < 6; i++)
            step(i < 3, (i == 0) ? rnd48(1'b1) : rnd48(1'b0), $urandom);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (dut_vec() !== {4'b0001, 80'h0}) begin
            n_fail++;
            $display("FAIL midreset_state: got %h, want %h", dut_vec(), {4'b0001, 80'h0});
        end
        @(negedge clk);
        rst = 1'b0;
        en_cnt = 0; rv_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, rnd48(1'b1), $urandom);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midreset_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
            if (en) en_cnt++;
            if (rsp_valid) rv_cnt++;
        end
        n_checks++;
        if (en_cnt != 0 || rv_cnt != 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got en %0d rsp %0d, want 0 and 0", en_cnt, rv_cnt);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, rnd48(1'($urandom)), $urandom);
            n_checks++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle %0d: got %h, want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_cmd_sequencer.md
I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries (power of two, >=2).
REQ-002 Parameter: WAIT_CYCLES, 200, clk cycles allowed per i2c transaction after the en pulse (>=1).
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 cmd_valid  input  1  upstream command offered.
REQ-007 cmd_ready  output  1  FIFO can accept a command.
REQ-008 cmd_slave_address  input  7  target slave address.
REQ-009 cmd_read_write  input  1  0 = write, 1 = read.
REQ-010 cmd_register_address  input  8  target register.
REQ-011 cmd_data  input  32  write data (ignored for reads).
REQ-012 en  output  1  one-cycle start pulse to the i2c block.
REQ-013 ext_slave_address_in / ext_read_write_in / ext_register_address_in / ext_data_in  output  7/1/8/32  transaction fields to the i2c block.
REQ-014 ext_data_out  input  32  read data returned by the i2c block.
REQ-015 rsp_valid  output  1  one-cycle pulse, read data available.
REQ-016 rsp_data  output  32  captured read data.
REQ-017 busy  output  1  high while FIFO non-empty or state != IDLE.

Function
REQ-018 FIFO SHALL store {address, rw, register, data} (48 bits); push on cmd_valid & cmd_ready; cmd_ready = registered count < DEPTH.
REQ-019 Full FIFO with pop in the same cycle SHALL NOT accept a push (cmd_ready depends only on registered count).
REQ-020 FSM states SHALL be IDLE, SETUP, PULSE, WAIT, CAPTURE.
REQ-021 IDLE: if FIFO non-empty, pop head into ext_* output registers, go SETUP; else stay.
REQ-022 SETUP: exactly one cycle, en = 0, ext_* stable; go PULSE.
REQ-023 PULSE: en = 1 for exactly one cycle; load counter WAIT_CYCLES-1; go WAIT.
REQ-024 WAIT: decrement counter; at 0 go CAPTURE if rw = 1, else IDLE.
REQ-025 On WAIT->CAPTURE edge rsp_data SHALL load ext_data_out; rsp_valid SHALL be 1 only while in CAPTURE; CAPTURE -> IDLE after one cycle.
REQ-026 ext_* outputs SHALL remain constant from SETUP through end of WAIT/CAPTURE and hold last values in IDLE.
REQ-027 rsp_data SHALL hold its value until the next read capture.
REQ-028 Latency: command accepted at edge k into empty FIFO, idle FSM -> SETUP at k+1, en high k+2..k+3, write returns IDLE at k+3+WAIT_CYCLES, read rsp_valid high k+3+WAIT_CYCLES..k+4+WAIT_CYCLES.
REQ-029 Back-to-back writes SHALL produce en pulses spaced WAIT_CYCLES+3 cycles; reads WAIT_CYCLES+4.
REQ-030 Commands SHALL be issued strictly in acceptance order; none dropped or duplicated.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 rst SHALL immediately force: state IDLE, FIFO empty, counter 0, en 0, rsp_valid 0, rsp_data 0, all ext_* 0, cmd_ready 1, busy 0.
REQ-033 Reset mid-transaction SHALL discard the in-flight command and all queued commands; no rsp_valid for discarded reads.

Verification (WAIT_CYCLES = 8)
REQ-034 Write 7'h63/0/8'h0b/32'h58ae1234 accepted at edge k -> single en pulse k+2, ext_* equal these values k+1..k+11, no rsp_valid, busy low from k+11.
REQ-035 Read 7'h63/1/8'h0f with ext_data_out = 32'hdeadbeef -> rsp_valid one cycle at k+11, rsp_data = 32'hdeadbeef afterwards.
REQ-036 Six consecutive pushes of writes (data 1..6) -> cmd_ready low once 4 queued, exactly accepted commands issued in order, en spacing 11 cycles.
REQ-037 FIFO full, FSM in IDLE pops while cmd_valid = 1 -> push refused that cycle, accepted next cycle, order preserved.
REQ-038 rst asserted during WAIT of a read with 2 queued commands -> en, rsp_valid 0 at once, busy 0, cmd_ready 1, no further en pulses after release.
